// File: rtl/keypad_scanner.sv
// -----------------------------------------------------------------------------
// keypad_scanner
//
// Purpose:
//   Scans a 4x4 matrix keypad by driving one column low at a time. Any low row
//   (which means a key is down) freezes the scan on that column. The press is
//   debounced, and then the key is reported as a one-cycle strobe with its
//   code. The key release is debounced too, and scanning then resumes at
//   column 0.
//
// Optional feature:
//   Define KEYPAD_REPEAT_EN to enable auto-repeat while a key is held.
//   - The first repeat strobe comes REPEAT_DELAY cycles after acceptance.
//   - Further strobes come every REPEAT_PERIOD cycles after that.
//   With the macro undefined, each press gives exactly one strobe.
//
// Parameters:
//   SCAN_DIV      cycles each column is driven per scan slot (>= 4)
//   DEBOUNCE_CNT  consecutive stable cycles needed to accept a press/release
//   REPEAT_DELAY  hold cycles before the first auto-repeat (repeat build only)
//   REPEAT_PERIOD cycles between later auto-repeats (repeat build only)
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   row_in     keypad rows, active-low, asynchronous to clk
//   col_out    column drive, one-hot active-low
//   key_code   last accepted key, row*4+col
//   key_valid  one-cycle strobe on acceptance (and on auto-repeat)
//   key_held   high while the accepted key is down or its release is debouncing
// -----------------------------------------------------------------------------
module keypad_scanner #(
  parameter int SCAN_DIV      = 50000,
  parameter int DEBOUNCE_CNT  = 500000,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 10000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int DB_W  = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CNT - 1);

  typedef enum logic [1:0] {
    SCAN       = 2'd0,
    PRESS_DB   = 2'd1,
    PRESSED    = 2'd2,
    RELEASE_DB = 2'd3
  } state_t;

  state_t           r_state;
  logic [3:0]       r_row_sync1;
  logic [3:0]       r_row_sync2;
  logic [1:0]       r_col;
  logic [1:0]       r_row;
  logic [3:0]       r_col_out;
  logic [DIV_W-1:0] r_div_cnt;
  logic [DB_W-1:0]  r_db_cnt;
  logic [3:0]       r_key_code;
  logic             r_key_valid;
  logic             r_key_held;

  logic             w_any_low;
  logic [1:0]       w_low_idx;
  logic             w_sel_low;
  logic [1:0]       w_col_next;

`ifdef KEYPAD_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W   = $clog2(REP_MAX + 1);

  // r_rep_phase = 0: waiting out the initial delay; 1: periodic repeats
  logic [REP_W-1:0] r_rep_cnt;
  logic             r_rep_phase;
  logic [REP_W-1:0] w_rep_last;
  logic             w_rep_hit;
  logic [REP_W-1:0] w_rep_inc;

  assign w_rep_last = r_rep_phase ? REP_W'(REPEAT_PERIOD - 1) : REP_W'(REPEAT_DELAY - 1);
  assign w_rep_hit  = (r_rep_cnt >= w_rep_last);
  // Saturating increment: during RELEASE_DB the timer may reach its terminal
  // value; it then waits there until the key settles back into PRESSED.
  assign w_rep_inc  = w_rep_hit ? r_rep_cnt : r_rep_cnt + 1'b1;
`endif

  // Active-low one-hot column drive
  function automatic logic [3:0] col_drive(input logic [1:0] c);
    col_drive = ~(4'b0001 << c);
  endfunction

  // Two-flop synchronizer. Rows idle high, so it resets to all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_row_sync1 <= 4'b1111;
      r_row_sync2 <= 4'b1111;
    end else begin
      r_row_sync1 <= row_in;
      r_row_sync2 <= r_row_sync1;
    end
  end

  // Lowest-index low row wins when several rows are low together
  always_comb begin
    w_low_idx = 2'd0;
    if (!r_row_sync2[0])      w_low_idx = 2'd0;
    else if (!r_row_sync2[1]) w_low_idx = 2'd1;
    else if (!r_row_sync2[2]) w_low_idx = 2'd2;
    else                      w_low_idx = 2'd3;
  end

  assign w_any_low  = ~&r_row_sync2;
  assign w_sel_low  = ~r_row_sync2[r_row];
  assign w_col_next = r_col + 2'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= SCAN;
      r_col       <= 2'd0;
      r_row       <= 2'd0;
      r_col_out   <= 4'b1110;
      r_div_cnt   <= '0;
      r_db_cnt    <= '0;
      r_key_code  <= 4'd0;
      r_key_valid <= 1'b0;
      r_key_held  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      r_rep_cnt   <= '0;
      r_rep_phase <= 1'b0;
`endif
    end else begin
      r_key_valid <= 1'b0;
      case (r_state)
        SCAN: begin
          if (r_div_cnt == DIV_LAST) begin
            r_div_cnt <= '0;
            if (w_any_low) begin
              // Column stays driven; col_out is simply not advanced
              r_row    <= w_low_idx;
              r_db_cnt <= '0;
              r_state  <= PRESS_DB;
            end else begin
              r_col     <= w_col_next;
              r_col_out <= col_drive(w_col_next);
            end
          end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
          end
        end

        PRESS_DB: begin
          if (!w_sel_low) begin
            // Bounce: abandon this key and carry on from the next column
            r_db_cnt  <= '0;
            r_div_cnt <= '0;
            r_col     <= w_col_next;
            r_col_out <= col_drive(w_col_next);
            r_state   <= SCAN;
          end else if (r_db_cnt == DB_LAST) begin
            r_db_cnt    <= '0;
            r_key_code  <= {r_row, r_col};
            r_key_valid <= 1'b1;
            r_key_held  <= 1'b1;
            r_state     <= PRESSED;
`ifdef KEYPAD_REPEAT_EN
            r_rep_cnt   <= '0;
            r_rep_phase <= 1'b0;
`endif
          end else begin
            r_db_cnt <= r_db_cnt + 1'b1;
          end
        end

        PRESSED: begin
          if (!w_sel_low) begin
            r_db_cnt <= '0;
            r_state  <= RELEASE_DB;
`ifdef KEYPAD_REPEAT_EN
            r_rep_cnt <= w_rep_inc;
`endif
          end else begin
`ifdef KEYPAD_REPEAT_EN
            if (w_rep_hit) begin
              r_key_valid <= 1'b1;
              r_rep_cnt   <= '0;
              r_rep_phase <= 1'b1;
            end else begin
              r_rep_cnt <= r_rep_cnt + 1'b1;
            end
`endif
          end
        end

        RELEASE_DB: begin
          if (w_sel_low) begin
            // Release glitch: the key is still down, so no new strobe
            r_db_cnt <= '0;
            r_state  <= PRESSED;
`ifdef KEYPAD_REPEAT_EN
            r_rep_cnt <= w_rep_inc;
`endif
          end else if (r_db_cnt == DB_LAST) begin
            r_db_cnt   <= '0;
            r_div_cnt  <= '0;
            r_col      <= 2'd0;
            r_col_out  <= 4'b1110;
            r_key_held <= 1'b0;
            r_state    <= SCAN;
          end else begin
            r_db_cnt <= r_db_cnt + 1'b1;
`ifdef KEYPAD_REPEAT_EN
            r_rep_cnt <= w_rep_inc;
`endif
          end
        end

        default: r_state <= SCAN;
      endcase
    end
  end

  assign col_out   = r_col_out;
  assign key_code  = r_key_code;
  assign key_valid = r_key_valid;
  assign key_held  = r_key_held;

endmodule
